sfx_scheduler: RTL and testbench
================================

# sfx_scheduler

Sound-effect scheduler that shares the speaker frequency outputs between the background-music path and four one-shot sound-effect requesters. It latches requests, grants the highest-priority pending effect, sequences that effect's four-note tone pattern, and overlays it on the BGM frequencies. It sits between the per-state BGM mux and the audio note generator, on the same clock as the sequencing logic.

## Interface
- NOTE_CYC, 2500000: clock cycles per effect note; legal range 1..2^24-1.
- SILENT, 50000000: frequency code meaning "no audible tone".
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mute  in  1  forces both outputs to SILENT; the scheduler keeps running.
- flush  in  1  synchronous abort: clears pending requests and any playing effect.
- req  in  4  one-cycle request pulses; bit 0 is highest priority.
- bgm_l, bgm_r  in  26  background-music frequencies for left and right.
- freqL, freqR  out  26  frequencies to the note generator.
- busy  out  1  high while an effect is playing.
- grant  out  2  ID of the effect playing or last played.
- done  out  1  one-cycle pulse when an effect completes naturally.

## Operation
- Registered state:
  - pending[3:0]
  - FSM {IDLE, PLAY}
  - grant[1:0]
  - note[1:0]
  - cnt[23:0]
  - done
- Request latch: each cycle, pending |= req, except for a req bit equal to grant while in PLAY, which is dropped. A set and a clear of the same pending bit in one cycle resolve to set. flush overrides everything: pending ← 0 and any req that cycle is dropped.
- IDLE with pending ≠ 0 and no flush:
  - grant ← lowest set index.
  - That pending bit is cleared.
  - note ← 0, cnt ← 0, state ← PLAY.
- PLAY, each cycle:
  - If cnt = NOTE_CYC-1: cnt ← 0 and note ← note+1.
  - Otherwise cnt ← cnt+1.
  - If note = 3 and cnt = NOTE_CYC-1: state ← IDLE and done ← 1 for one cycle.
- Preemption: in PLAY, if any pending bit has index < grant, the effect is reloaded with the new ID the next cycle (same actions as the IDLE grant, note/cnt reset). The preempted effect is discarded and produces no done.
- flush in PLAY: state ← IDLE next edge, no done.
- Tone ROM, indexed by grant and note, notes 0..3 in Hz:
  - ID0: 1047, 784, 523, 262.
  - ID1: 523, 659, 784, 1047.
  - ID2: 880, SILENT, 880, SILENT.
  - ID3: 440, 440, 440, 440.
- Output mux (combinational from registers and inputs):
  - mute: freqL = freqR = SILENT.
  - Else PLAY: freqL = freqR = ROM tone.
  - Else: freqL = bgm_l, freqR = bgm_r.
- busy = (state == PLAY).

## Timing
- Reset values:
  - State IDLE; pending, grant, note, cnt and done all 0; busy 0.
  - freqL/freqR follow bgm_l/bgm_r, or SILENT if mute.
- Latency: req pulse at edge k sets pending at k. The grant and PLAY take effect at edge k+1, so the tone appears on freqL/freqR after edge k+1.
- Effect duration: exactly 4·NOTE_CYC cycles in PLAY. done is asserted on the cycle immediately after the last PLAY cycle, concurrent with the first IDLE cycle.
- Back-to-back: after completion, one IDLE cycle elapses before the next pending effect is granted. BGM is visible on the outputs during that cycle.
- NOTE_CYC = 1: the note advances every cycle; the effect lasts 4 cycles.
- The counter never exceeds NOTE_CYC-1, and the note wraps only via the return to IDLE.
- rst mid-effect: immediate return to reset values, with no done.
- mute does not stall counters. An effect that completes while muted still pulses done.

## Test plan
- Single request (NOTE_CYC=4): req=0010 for one cycle.
  - busy=1 and grant=1 from the next edge.
  - freqL sequence is 523×4, 659×4, 784×4, 1047×4.
  - done pulses once, 16 cycles later.
  - Outputs then return to bgm_l/bgm_r.
- Simultaneous requests: req=1010 in one cycle.
  - ID1 plays first.
  - done, then one IDLE cycle, then ID3 plays 440×16.
  - done pulses twice in total.
- Preemption: ID2 playing at cycle 5, req=0001.
  - ID0 starts next edge, producing 1047×4 and onward.
  - Only one done, at ID0's end; ID2 is never resumed.
- Self re-request: during ID3 playback, pulse req=1000.
  - The request is dropped.
  - After done, busy stays 0 and pending = 0.
- flush and mute:
  - flush mid-effect: busy=0 the next cycle, no done, pending cleared even with a concurrent req.
  - mute=1 mid-effect: freqL=freqR=50000000, but done still arrives at the normal cycle.
- Async reset: assert rst between edges during PLAY.
  - busy/grant/done drop immediately.
  - Outputs show bgm_l/bgm_r.

Source files
------------

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches one-shot effect requests, plays the highest-priority one as a
// four-note tone pattern and overlays it on the background-music frequencies.
module sfx_scheduler #(
  parameter int unsigned NOTE_CYC = 2500000,
  parameter int unsigned SILENT   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mute,
  input  logic        flush,
  input  logic [3:0]  req,
  input  logic [25:0] bgm_l,
  input  logic [25:0] bgm_r,
  output logic [25:0] freqL,
  output logic [25:0] freqR,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        done
);

  typedef enum logic {StIdle, StPlay} state_e;

  localparam logic [23:0] CntLast = 24'(NOTE_CYC - 1);
  localparam logic [25:0] Silent  = 26'(SILENT);

  state_e      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  note_q, note_d;
  logic [23:0] cnt_q, cnt_d;
  logic        done_q, done_d;

  logic [1:0]  low_idx;
  logic        any_pend, preempt, last_cyc;
  logic [3:0]  pend_clr, req_keep;
  logic [25:0] tone;

  // Bit 0 is highest priority, so scan from the top down and let the lowest set bit win.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 2'(i);
    end
  end

  assign any_pend = |pending_q;
  assign preempt  = any_pend && (low_idx < grant_q);
  assign last_cyc = (note_q == 2'd3) && (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    note_d   = note_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    pend_clr = '0;
    req_keep = req;
    // A request for the effect already playing is dropped.
    if (state_q == StPlay) req_keep[grant_q] = 1'b0;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_pend) begin
            grant_d           = low_idx;
            pend_clr[low_idx] = 1'b1;
            note_d            = 2'd0;
            cnt_d             = '0;
            state_d           = StPlay;
          end
        end
        StPlay: begin
          if (preempt) begin
            grant_d           = low_idx;
            pend_clr[low_idx] = 1'b1;
            note_d            = 2'd0;
            cnt_d             = '0;
          end else begin
            if (cnt_q == CntLast) begin
              cnt_d  = '0;
              note_d = note_q + 2'd1;
            end else begin
              cnt_d = cnt_q + 24'd1;
            end
            if (last_cyc) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // New requests win over the grant-time clear of the same bit.
    pending_d = flush ? 4'b0 : ((pending_q & ~pend_clr) | req_keep);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      grant_q   <= '0;
      note_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      note_q    <= note_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    tone = Silent;
    unique case ({grant_q, note_q})
      4'h0: tone = 26'd1047;
      4'h1: tone = 26'd784;
      4'h2: tone = 26'd523;
      4'h3: tone = 26'd262;
      4'h4: tone = 26'd523;
      4'h5: tone = 26'd659;
      4'h6: tone = 26'd784;
      4'h7: tone = 26'd1047;
      4'h8: tone = 26'd880;
      4'h9: tone = Silent;
      4'ha: tone = 26'd880;
      4'hb: tone = Silent;
      4'hc: tone = 26'd440;
      4'hd: tone = 26'd440;
      4'he: tone = 26'd440;
      4'hf: tone = 26'd440;
      default: tone = Silent;
    endcase
  end

  always_comb begin
    if (mute) begin
      freqL = Silent;
      freqR = Silent;
    end else if (state_q == StPlay) begin
      freqL = tone;
      freqR = tone;
    end else begin
      freqL = bgm_l;
      freqR = bgm_r;
    end
  end

  assign busy  = (state_q == StPlay);
  assign grant = grant_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios plus random traffic, all checked every cycle
// against a reference model that tracks elapsed time inside the current effect.
module tb_sfx_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned SIL = 50000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mute = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [25:0] bgm_l = 26'd0;
  logic [25:0] bgm_r = 26'd0;
  logic [25:0] freqL, freqR;
  logic        busy, done;
  logic [1:0]  grant;

  sfx_scheduler #(.NOTE_CYC(N), .SILENT(SIL)) dut (
    .clk   (clk),
    .rst   (rst),
    .mute  (mute),
    .flush (flush),
    .req   (req),
    .bgm_l (bgm_l),
    .bgm_r (bgm_r),
    .freqL (freqL),
    .freqR (freqR),
    .busy  (busy),
    .grant (grant),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  // Reference model: pending set, playing flag, effect ID and cycles elapsed in the effect.
  bit [3:0] m_pend;
  bit       m_play;
  int       m_id;
  int       m_el;
  bit       m_done;

  int tones [4][4] = '{'{1047, 784, 523, 262},
                       '{523, 659, 784, 1047},
                       '{880, SIL, 880, SIL},
                       '{440, 440, 440, 440}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_play = 1'b0;
    m_id   = 0;
    m_el   = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    bit [3:0] nreq;
    int       lo;
    nreq   = req;
    m_done = 1'b0;
    if (flush) begin
      m_pend = '0;
      m_play = 1'b0;
      return;
    end
    if (m_play) nreq[m_id] = 1'b0;
    lo = lowest(m_pend);
    if (m_play) begin
      if (lo >= 0 && lo < m_id) begin
        m_id = lo; m_el = 0; m_pend[lo] = 1'b0;
      end else if (m_el == 4 * N - 1) begin
        m_play = 1'b0; m_done = 1'b1;
      end else begin
        m_el++;
      end
    end else if (lo >= 0) begin
      m_id = lo; m_el = 0; m_play = 1'b1; m_pend[lo] = 1'b0;
    end
    m_pend = m_pend | nreq;
  endtask

  task automatic check_outputs();
    int el, er;
    el = mute ? SIL : (m_play ? tones[m_id][m_el / N] : int'(bgm_l));
    er = mute ? SIL : (m_play ? tones[m_id][m_el / N] : int'(bgm_r));
    check("freqL", 32'(freqL), el);
    check("freqR", 32'(freqR), er);
    check("busy", 32'(busy), 32'(m_play));
    check("grant", 32'(grant), m_id);
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic cycle(input logic [3:0] r, input logic f, input logic m);
    @(negedge clk);
    req   = r;
    flush = f;
    mute  = m;
    bgm_l = 26'($urandom);
    bgm_r = 26'($urandom);
    #1;
    check_outputs();
    if (done) done_seen++;
    @(posedge clk);
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) cycle(4'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    bgm_l = 26'd1234;
    bgm_r = 26'd5678;
    #2;
    check_outputs();
    mute = 1'b1;
    #1;
    check("rst_mute_l", 32'(freqL), SIL);
    mute = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single request.
    done_seen = 0;
    cycle(4'b0010, 1'b0, 1'b0);
    run(20);
    check("single_done_cnt", done_seen, 1);

    // Two simultaneous requests, ID1 then ID3.
    done_seen = 0;
    cycle(4'b1010, 1'b0, 1'b0);
    run(40);
    check("dual_done_cnt", done_seen, 2);

    // ID2 preempted by ID0.
    done_seen = 0;
    cycle(4'b0100, 1'b0, 1'b0);
    run(4);
    cycle(4'b0001, 1'b0, 1'b0);
    run(20);
    check("preempt_done_cnt", done_seen, 1);

    // Self re-request while ID3 plays is dropped.
    done_seen = 0;
    cycle(4'b1000, 1'b0, 1'b0);
    run(5);
    cycle(4'b1000, 1'b0, 1'b0);
    run(22);
    check("selfreq_done_cnt", done_seen, 1);
    check("selfreq_idle", 32'(busy), 0);

    // Flush mid-effect with a concurrent request.
    done_seen = 0;
    cycle(4'b0010, 1'b0, 1'b0);
    run(5);
    cycle(4'b0100, 1'b1, 1'b0);
    run(6);
    check("flush_done_cnt", done_seen, 0);
    check("flush_idle", 32'(busy), 0);

    // Muted effect still completes.
    done_seen = 0;
    cycle(4'b0001, 1'b0, 1'b0);
    run(3);
    repeat (20) cycle(4'b0, 1'b0, 1'b1);
    check("mute_done_cnt", done_seen, 1);

    // Asynchronous reset mid-effect.
    cycle(4'b0100, 1'b0, 1'b0);
    run(6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_grant", 32'(grant), 0);
    check("arst_done", 32'(done), 0);
    check("arst_freqL", 32'(freqL), 32'(bgm_l));
    check("arst_freqR", 32'(freqR), 32'(bgm_r));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(3);

    // Random traffic.
    repeat (3000) begin
      logic [3:0] r;
      logic       f, m;
      r = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      f = ($urandom_range(0, 63) == 0);
      m = ($urandom_range(0, 7) == 0);
      cycle(r, f, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
